camera_roi_rx: RTL and testbench
================================

# camera_roi_rx

Parametrised successor to the basic camera capture block for parallel sensors with FRAME_VALID/LINE_VALID framing, such as the MT9V034.
- Registers pixel data of configurable width.
- Rejects a partial first frame after reset.
- Crops each frame to a runtime region of interest (ROI) and emits ROI-relative coordinates.
- Adds frame strobes, a frame counter and sticky geometry-error flags.
- Sits between the sensor pads and downstream line buffers/processing, all in the PIXCLK domain.

## Interface
- H, 752: maximum active pixels per line.
- V, 480: maximum active lines per frame.
- DW, 10: pixel data width.
- PIXCLK in 1: pixel clock; all logic on rising edge.
- RST in 1: synchronous, active-high reset.
- FRAME_VALID in 1: sensor frame valid.
- LINE_VALID in 1: sensor line valid.
- DATA_IN in DW: sensor pixel.
- ROI_X0 in $clog2(H): first ROI column.
- ROI_Y0 in $clog2(V): first ROI line.
- ROI_W in $clog2(H+1): ROI width in pixels; 0 means no output.
- ROI_H in $clog2(V+1): ROI height in lines; 0 means no output.
- DECIM in 2: decimation select; 0 = 1x, 1 = 2x, 2 = 4x, 3 = 4x.
- ERR_CLR in 1: clears both error flags.
- DATA_OUT out DW: registered pixel.
- PIXEL_VALID out 1: DATA_OUT is valid and inside the ROI.
- CURRENT_LINE out $clog2(V): ROI-relative line of DATA_OUT.
- CURRENT_COLUMN out $clog2(H): ROI-relative column of DATA_OUT.
- FRAME_START out 1: one-cycle pulse at frame start.
- FRAME_END out 1: one-cycle pulse at frame end.
- FRAME_CNT out 16: completed frames, wraps at 65535 to 0.
- ERR_LINE_LONG out 1: sticky; a line had more than H pixels.
- ERR_FRAME_LONG out 1: sticky; a frame had more than V lines.

## Operation
- **Input stage:** FRAME_VALID, LINE_VALID and DATA_IN are registered into fv1, lv1, d1. Edges are detected from fv1/lv1 against their one-cycle-delayed copies fv2/lv2.
- **States:**
  - WAIT_IDLE (reset state): go to IDLE when fv1=0. A frame already in progress at reset is never captured.
  - IDLE: go to ACTIVE on an fv1 rising edge. Latch ROI_X0/Y0/W/H and DECIM into shadow registers and pulse FRAME_START.
  - ACTIVE: go to IDLE when fv1=0. Pulse FRAME_END and increment FRAME_CNT.
- **Column counter col:**
  - Cleared whenever lv1=0.
  - Increments on every lv1=1 cycle in ACTIVE.
  - Saturates at H. A pixel sampled at col=H sets ERR_LINE_LONG and is suppressed.
- **Line counter row:**
  - Cleared in IDLE.
  - Increments on each lv1 falling edge in ACTIVE.
  - Saturates at V. Any lv1=1 cycle with row=V sets ERR_FRAME_LONG and is suppressed.
- **Unterminated line:** if fv1 falls while lv1=1, that line is truncated. It does not count as a line-length error.
- **ROI test:** a pixel is in the ROI when col<H, row<V, (col−X0)<W and (row−Y0)<H_roi.
  - Subtractions are unsigned with one extra bit, so col<X0 or row<Y0 fails the test.
  - An ROI extending past H/V is clipped naturally.
- **Outputs:**
  - CURRENT_COLUMN = col−X0 and CURRENT_LINE = row−Y0, after decimation scaling.
  - DATA_OUT = d1, registered every cycle regardless of validity.
- **Error flags:** ERR_CLR clears both flags. A set event in the same cycle as ERR_CLR wins.
- **Shadow ROI:** ROI inputs changing mid-frame have no effect until the next FRAME_START.

## Timing
- The sample taken at rising edge k appears on DATA_OUT/PIXEL_VALID/coordinates after edge k+2. Fixed 2-cycle latency.
- FRAME_START is high for the cycle after edge k+2, where edge k sampled the first FRAME_VALID=1.
- FRAME_END is high for the cycle after edge k+2, where edge k sampled the first FRAME_VALID=0. FRAME_CNT updates on that same edge.
- Error flags assert in the cycle after edge k+2 of the offending sample.
- **RST:** takes effect at the next edge. All outputs, counters, shadow registers, fv1/lv1/fv2/lv2 and FRAME_CNT go to 0; state goes to WAIT_IDLE. An RST pulse mid-frame discards the rest of that frame, with no FRAME_END.
- **Back-to-back frames:** fv1 low for a single cycle between frames gives FRAME_END and FRAME_START on consecutive cycles.

## Configuration
- **CAMERA_RX_DECIM_EN defined:** the shadow DECIM value sets a factor of 1, 2 or 4.
  - PIXEL_VALID additionally requires (col−X0) and (row−Y0) to be multiples of the factor.
  - Output coordinates are divided by the factor (right shift).
- **CAMERA_RX_DECIM_EN undefined:** the DECIM port is present but ignored, and the factor is always 1. No decimation logic is synthesised.

## Test plan
Unless noted, H=8, V=4, DW=10.
- **Partial first frame:** release RST with FRAME_VALID=1 for 20 cycles, then a full 8×4 frame. Expect no PIXEL_VALID during the first 20 cycles, FRAME_START once, 32 valid pixels, then FRAME_END and FRAME_CNT=1.
- **Crop:** ROI X0=2, Y0=1, W=3, H=2, data = row*8+col. Expect 6 valid pixels with values 10,11,12,18,19,20 at coordinates (0,0)…(1,2), each 2 cycles after its input.
- **Overrun:** one line of 10 pixels, then a frame of 5 lines. Expect ERR_LINE_LONG after the 9th pixel and only 8 pixels output for that line. Expect ERR_FRAME_LONG on line 5. ERR_CLR then clears both flags.
- **Mid-frame ROI change:** change ROI_X0 from 0 to 4 mid-frame. The current frame is unaffected; the next frame starts output at column 4.
- **Reset mid-frame:** assert RST at line 2 of a frame. All outputs are 0 next cycle and there is no FRAME_END. The following complete frame captures normally with FRAME_CNT=1.
- **Decimation (CAMERA_RX_DECIM_EN defined):** DECIM=1 on a full 8×4 ROI. Expect 8 valid pixels, coordinates 0–3 × 0–1, values 0,2,4,6,16,18,20,22.

Source files
------------

// File: rtl/camera_roi_rx.sv
// Parallel-sensor capture with ROI cropping, frame strobes/counter and sticky geometry errors.
// Optional decimation is compiled in when CAMERA_RX_DECIM_EN is defined.
module camera_roi_rx #(
    parameter int unsigned H  = 752,
    parameter int unsigned V  = 480,
    parameter int unsigned DW = 10
) (
    input  logic                   PIXCLK,
    input  logic                   RST,
    input  logic                   FRAME_VALID,
    input  logic                   LINE_VALID,
    input  logic [DW-1:0]          DATA_IN,
    input  logic [$clog2(H)-1:0]   ROI_X0,
    input  logic [$clog2(V)-1:0]   ROI_Y0,
    input  logic [$clog2(H+1)-1:0] ROI_W,
    input  logic [$clog2(V+1)-1:0] ROI_H,
    input  logic [1:0]             DECIM,
    input  logic                   ERR_CLR,
    output logic [DW-1:0]          DATA_OUT,
    output logic                   PIXEL_VALID,
    output logic [$clog2(V)-1:0]   CURRENT_LINE,
    output logic [$clog2(H)-1:0]   CURRENT_COLUMN,
    output logic                   FRAME_START,
    output logic                   FRAME_END,
    output logic [15:0]            FRAME_CNT,
    output logic                   ERR_LINE_LONG,
    output logic                   ERR_FRAME_LONG
);
    localparam int unsigned XW = $clog2(H);
    localparam int unsigned YW = $clog2(V);
    localparam int unsigned CW = $clog2(H + 1);
    localparam int unsigned RW = $clog2(V + 1);

    typedef enum logic [1:0] {StWaitIdle, StIdle, StActive} state_t;

    state_t          state;
    logic            fv1, lv1, fv2, lv2, s1;
    logic [DW-1:0]   d1;
    logic [XW-1:0]   x0_s;
    logic [YW-1:0]   y0_s;
    logic [CW-1:0]   w_s;
    logic [RW-1:0]   h_s;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;

    logic            v2, fs2, fe2, ell2, efl2;
    logic [DW-1:0]   d2;
    logic [XW-1:0]   cx2;
    logic [YW-1:0]   cy2;

    logic            fv_rise, lv_fall, pix, col_full, row_full, in_roi, on_grid, pix_ok;
    logic [CW:0]     dx;
    logic [RW:0]     dy;
    logic [XW-1:0]   cx;
    logic [YW-1:0]   cy;

`ifdef CAMERA_RX_DECIM_EN
    logic [1:0]      decim_s;
    logic [1:0]      shift;
    logic [1:0]      dmask;
`else
    logic            unused_decim;
    assign unused_decim = ^DECIM;
`endif

    always_comb begin
        fv_rise  = fv1 && !fv2;
        lv_fall  = lv2 && !lv1;
        pix      = (state == StActive) && fv1 && lv1;
        col_full = (col == CW'(H));
        row_full = (row == RW'(V));
        // One extra bit so that col<X0 / row<Y0 wraps to a large value and fails the test.
        dx       = (CW+1)'(col) - (CW+1)'(x0_s);
        dy       = (RW+1)'(row) - (RW+1)'(y0_s);
        in_roi   = (col < CW'(H)) && (row < RW'(V)) &&
                   (dx < (CW+1)'(w_s)) && (dy < (RW+1)'(h_s));
`ifdef CAMERA_RX_DECIM_EN
        unique case (decim_s)
            2'd0:    begin shift = 2'd0; dmask = 2'b00; end
            2'd1:    begin shift = 2'd1; dmask = 2'b01; end
            default: begin shift = 2'd2; dmask = 2'b11; end
        endcase
        on_grid = ((dx[1:0] & dmask) == 2'b00) && ((dy[1:0] & dmask) == 2'b00);
        cx      = XW'(dx >> shift);
        cy      = YW'(dy >> shift);
`else
        on_grid = 1'b1;
        cx      = XW'(dx);
        cy      = YW'(dy);
`endif
        pix_ok  = pix && in_roi && on_grid;
    end

    always_ff @(posedge PIXCLK) begin
        if (RST) begin
            state <= StWaitIdle;
            fv1   <= 1'b0;
            lv1   <= 1'b0;
            fv2   <= 1'b0;
            lv2   <= 1'b0;
            s1    <= 1'b0;
            d1    <= '0;
            x0_s  <= '0;
            y0_s  <= '0;
            w_s   <= '0;
            h_s   <= '0;
`ifdef CAMERA_RX_DECIM_EN
            decim_s <= '0;
`endif
            col   <= '0;
            row   <= '0;
            fs2   <= 1'b0;
            fe2   <= 1'b0;
        end else begin
            fv1 <= FRAME_VALID;
            lv1 <= LINE_VALID;
            d1  <= DATA_IN;
            fv2 <= fv1;
            lv2 <= lv1;
            // fv1 only holds a real sample once s1 is set; avoids the reset-cleared fv1
            // being mistaken for a gap in a frame that was already running.
            s1  <= 1'b1;
            fs2 <= 1'b0;
            fe2 <= 1'b0;
            unique case (state)
                StWaitIdle: if (s1 && !fv1) state <= StIdle;
                StIdle: begin
                    if (fv_rise) begin
                        state <= StActive;
                        x0_s  <= ROI_X0;
                        y0_s  <= ROI_Y0;
                        w_s   <= ROI_W;
                        h_s   <= ROI_H;
`ifdef CAMERA_RX_DECIM_EN
                        decim_s <= DECIM;
`endif
                        fs2   <= 1'b1;
                    end
                end
                StActive: begin
                    if (!fv1) begin
                        state <= StIdle;
                        fe2   <= 1'b1;
                    end
                end
                default: state <= StWaitIdle;
            endcase

            if (!lv1) col <= '0;
            else if (pix && !col_full) col <= col + CW'(1);

            if (state == StIdle) row <= '0;
            else if (state == StActive && lv_fall && !row_full) row <= row + RW'(1);
        end
    end

    always_ff @(posedge PIXCLK) begin
        if (RST) begin
            v2             <= 1'b0;
            d2             <= '0;
            cx2            <= '0;
            cy2            <= '0;
            ell2           <= 1'b0;
            efl2           <= 1'b0;
            DATA_OUT       <= '0;
            PIXEL_VALID    <= 1'b0;
            CURRENT_LINE   <= '0;
            CURRENT_COLUMN <= '0;
            FRAME_START    <= 1'b0;
            FRAME_END      <= 1'b0;
            FRAME_CNT      <= '0;
            ERR_LINE_LONG  <= 1'b0;
            ERR_FRAME_LONG <= 1'b0;
        end else begin
            v2             <= pix_ok;
            d2             <= d1;
            cx2            <= cx;
            cy2            <= cy;
            ell2           <= pix && col_full;
            efl2           <= pix && row_full;
            DATA_OUT       <= d2;
            PIXEL_VALID    <= v2;
            CURRENT_LINE   <= cy2;
            CURRENT_COLUMN <= cx2;
            FRAME_START    <= fs2;
            FRAME_END      <= fe2;
            FRAME_CNT      <= FRAME_CNT + 16'(fe2);
            if (ell2) ERR_LINE_LONG <= 1'b1;
            else if (ERR_CLR) ERR_LINE_LONG <= 1'b0;
            if (efl2) ERR_FRAME_LONG <= 1'b1;
            else if (ERR_CLR) ERR_FRAME_LONG <= 1'b0;
        end
    end

endmodule

// File: tb/tb_camera_roi_rx.sv
// Scoreboard bench for camera_roi_rx (H=8, V=4, DW=10): stimulus pushes expected pixels,
// a negedge monitor pops and compares them, including the fixed 2-cycle latency.
module tb_camera_roi_rx;
    localparam int H = 8;
    localparam int V = 4;
    localparam int DW = 10;

    logic          PIXCLK = 1'b0;
    logic          RST, FRAME_VALID, LINE_VALID, ERR_CLR;
    logic [DW-1:0] DATA_IN;
    logic [2:0]    ROI_X0;
    logic [1:0]    ROI_Y0;
    logic [3:0]    ROI_W;
    logic [2:0]    ROI_H;
    logic [1:0]    DECIM;
    logic [DW-1:0] DATA_OUT;
    logic          PIXEL_VALID, FRAME_START, FRAME_END, ERR_LINE_LONG, ERR_FRAME_LONG;
    logic [1:0]    CURRENT_LINE;
    logic [2:0]    CURRENT_COLUMN;
    logic [15:0]   FRAME_CNT;

    camera_roi_rx #(.H(H), .V(V), .DW(DW)) dut (
        .PIXCLK(PIXCLK), .RST(RST), .FRAME_VALID(FRAME_VALID), .LINE_VALID(LINE_VALID),
        .DATA_IN(DATA_IN), .ROI_X0(ROI_X0), .ROI_Y0(ROI_Y0), .ROI_W(ROI_W), .ROI_H(ROI_H),
        .DECIM(DECIM), .ERR_CLR(ERR_CLR), .DATA_OUT(DATA_OUT), .PIXEL_VALID(PIXEL_VALID),
        .CURRENT_LINE(CURRENT_LINE), .CURRENT_COLUMN(CURRENT_COLUMN),
        .FRAME_START(FRAME_START), .FRAME_END(FRAME_END), .FRAME_CNT(FRAME_CNT),
        .ERR_LINE_LONG(ERR_LINE_LONG), .ERR_FRAME_LONG(ERR_FRAME_LONG)
    );

    always #5 PIXCLK = ~PIXCLK;

    typedef struct {
        int data;
        int line;
        int col;
        int r;
        int c;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   fs_cnt = 0;
    int   fe_cnt = 0;
    int   ell_cyc = -1;
    int   efl_cyc = -1;
    logic ell_prev = 1'b0;
    logic efl_prev = 1'b0;
    int   sample_edge [0:7][0:15];

    always @(posedge PIXCLK) cyc <= cyc + 1;

    always @(negedge PIXCLK) begin
        if (PIXEL_VALID) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pixel: got data=%0d line=%0d col=%0d at cyc=%0d, required none",
                         DATA_OUT, CURRENT_LINE, CURRENT_COLUMN, cyc);
            end else begin
                e = exp_q.pop_front();
                if (int'(DATA_OUT) != e.data || int'(CURRENT_LINE) != e.line ||
                    int'(CURRENT_COLUMN) != e.col || cyc != sample_edge[e.r][e.c] + 2) begin
                    bad++;
                    $display("FAIL pixel: got data=%0d line=%0d col=%0d cyc=%0d, required data=%0d line=%0d col=%0d cyc=%0d",
                             DATA_OUT, CURRENT_LINE, CURRENT_COLUMN, cyc,
                             e.data, e.line, e.col, sample_edge[e.r][e.c] + 2);
                end
            end
        end
        if (FRAME_START) fs_cnt++;
        if (FRAME_END) fe_cnt++;
        if (ERR_LINE_LONG && !ell_prev) ell_cyc = cyc;
        if (ERR_FRAME_LONG && !efl_prev) efl_cyc = cyc;
        ell_prev = ERR_LINE_LONG;
        efl_prev = ERR_FRAME_LONG;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic drv(input logic fv, input logic lv, input int d);
        FRAME_VALID = fv;
        LINE_VALID  = lv;
        DATA_IN     = DW'(d);
        @(posedge PIXCLK);
        #1;
    endtask

    task automatic push(input int d, input int l, input int c, input int r, input int ci);
        exp_q.push_back('{d, l, c, r, ci});
    endtask

    task automatic push_full(input int nl);
        for (int r = 0; r < nl; r++)
            for (int c = 0; c < 8; c++) push(r * 8 + c, r, c, r, c);
    endtask

    task automatic set_roi(input int x0, input int y0, input int w, input int h);
        ROI_X0 = 3'(x0);
        ROI_Y0 = 2'(y0);
        ROI_W  = 4'(w);
        ROI_H  = 3'(h);
    endtask

    // Line r pixel c carries r*8+c; mid_line/mid_x0 rewrite ROI_X0 at the start of that line.
    task automatic frame(input int nl, input int np0, input int np, input int mid_line,
                         input int mid_x0);
        int n;
        drv(1'b1, 1'b0, 0);
        drv(1'b1, 1'b0, 0);
        for (int r = 0; r < nl; r++) begin
            if (r == mid_line) ROI_X0 = 3'(mid_x0);
            n = (r == 0) ? np0 : np;
            for (int c = 0; c < n; c++) begin
                sample_edge[r][c] = cyc + 1;
                drv(1'b1, 1'b1, r * 8 + c);
            end
            drv(1'b1, 1'b0, 0);
            drv(1'b1, 1'b0, 0);
        end
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pixel_valid"}, int'(PIXEL_VALID), 0);
        chk({tag, "_data_out"}, int'(DATA_OUT), 0);
        chk({tag, "_frame_cnt"}, int'(FRAME_CNT), 0);
        chk({tag, "_coords"}, int'(CURRENT_LINE) + int'(CURRENT_COLUMN), 0);
        chk({tag, "_strobes"}, int'(FRAME_START) + int'(FRAME_END), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe_before;
        RST = 1'b1; ERR_CLR = 1'b0; DECIM = 2'd0;
        set_roi(0, 0, 8, 4);
        drv(1'b1, 1'b0, 0);
        drv(1'b1, 1'b0, 0);
        drv(1'b1, 1'b0, 0);
        chk_zero("reset");
        chk("reset_err_line", int'(ERR_LINE_LONG), 0);

        // Partial first frame: released with FRAME_VALID already high.
        RST = 1'b0;
        for (int i = 0; i < 20; i++) drv(1'b1, (i % 4) != 0, i + 100);
        chk("partial_no_start", fs_cnt, 0);
        drv(1'b0, 1'b0, 0);
        drv(1'b0, 1'b0, 0);
        push_full(4);
        frame(4, 8, 8, -1, 0);
        chk("first_frame_starts", fs_cnt, 1);
        chk("first_frame_ends", fe_cnt, 1);
        chk("first_frame_cnt", int'(FRAME_CNT), 1);
        chk("first_frame_drained", exp_q.size(), 0);
        chk("first_frame_no_err", int'(ERR_LINE_LONG) + int'(ERR_FRAME_LONG), 0);

        // Crop X0=2 Y0=1 W=3 H=2.
        set_roi(2, 1, 3, 2);
        push(10, 0, 0, 1, 2); push(11, 0, 1, 1, 3); push(12, 0, 2, 1, 4);
        push(18, 1, 0, 2, 2); push(19, 1, 1, 2, 3); push(20, 1, 2, 2, 4);
        frame(4, 8, 8, -1, 0);
        chk("crop_drained", exp_q.size(), 0);
        chk("crop_frame_cnt", int'(FRAME_CNT), 2);

        // Overrun: a 10-pixel line, then a 5-line frame.
        set_roi(0, 0, 8, 4);
        push_full(1);
        frame(1, 10, 8, -1, 0);
        chk("line_long_flag", int'(ERR_LINE_LONG), 1);
        chk("line_long_time", ell_cyc, sample_edge[0][8] + 2);
        chk("line_long_drained", exp_q.size(), 0);
        chk("frame_long_clear", int'(ERR_FRAME_LONG), 0);
        push_full(4);
        frame(5, 8, 8, -1, 0);
        chk("frame_long_flag", int'(ERR_FRAME_LONG), 1);
        chk("frame_long_time", efl_cyc, sample_edge[4][0] + 2);
        chk("frame_long_drained", exp_q.size(), 0);
        ERR_CLR = 1'b1;
        drv(1'b0, 1'b0, 0);
        ERR_CLR = 1'b0;
        chk("err_clr_line", int'(ERR_LINE_LONG), 0);
        chk("err_clr_frame", int'(ERR_FRAME_LONG), 0);
        chk("overrun_frame_cnt", int'(FRAME_CNT), 4);

        // ROI_X0 changes 0->4 during line 2; only the next frame sees it.
        push_full(4);
        frame(4, 8, 8, 2, 4);
        chk("roi_hold_drained", exp_q.size(), 0);
        for (int r = 0; r < 4; r++)
            for (int c = 4; c < 8; c++) push(r * 8 + c, r, c - 4, r, c);
        frame(4, 8, 8, -1, 0);
        chk("roi_new_drained", exp_q.size(), 0);
        chk("roi_frame_cnt", int'(FRAME_CNT), 6);
        ROI_X0 = 3'd0;

        // Reset asserted as line 2 starts.
        push_full(2);
        drv(1'b1, 1'b0, 1000);
        drv(1'b1, 1'b0, 1000);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 8; c++) begin
                sample_edge[r][c] = cyc + 1;
                drv(1'b1, 1'b1, r * 8 + c);
            end
            drv(1'b1, 1'b0, 1000);
            drv(1'b1, 1'b0, 1000);
        end
        RST = 1'b1;
        drv(1'b1, 1'b1, 16);
        chk_zero("mid_reset");
        chk("mid_reset_drained", exp_q.size(), 0);
        RST = 1'b0;
        fe_before = fe_cnt;
        for (int i = 0; i < 3; i++) drv(1'b1, 1'b1, 17 + i);
        drv(1'b1, 1'b0, 0);
        drv(1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b0, 0);
        chk("mid_reset_no_end", fe_cnt, fe_before);
        push_full(4);
        frame(4, 8, 8, -1, 0);
        chk("after_reset_cnt", int'(FRAME_CNT), 1);
        chk("after_reset_drained", exp_q.size(), 0);

`ifdef CAMERA_RX_DECIM_EN
        DECIM = 2'd1;
        push(0, 0, 0, 0, 0);  push(2, 0, 1, 0, 2);  push(4, 0, 2, 0, 4);  push(6, 0, 3, 0, 6);
        push(16, 1, 0, 2, 0); push(18, 1, 1, 2, 2); push(20, 1, 2, 2, 4); push(22, 1, 3, 2, 6);
        frame(4, 8, 8, -1, 0);
        chk("decim_drained", exp_q.size(), 0);
        chk("decim_frame_cnt", int'(FRAME_CNT), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
